// File: rtl/debug_probe_if.sv
// -----------------------------------------------------------------------------
// debug_probe_if
// Bundles the host command handshake, the core debug pins and the captured-word
// output stream of debug_probe.
//   master : the probe side (drives cmd_ready, debug_*, out_*, busy)
//   slave  : host/core side (drives cmd_valid/run/steps, debug_data, out_ready)
// Parameter STEP_W sets the width of cmd_steps and must match debug_probe.
// -----------------------------------------------------------------------------
interface debug_probe_if #(
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_run;
    logic [STEP_W-1:0] cmd_steps;
    logic              debug_en;
    logic              debug_step;
    logic [6:0]        debug_addr;
    logic [31:0]       debug_data;
    logic              out_valid;
    logic              out_ready;
    logic [5:0]        out_addr;
    logic [31:0]       out_data;
    logic              out_last;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_run, cmd_steps, debug_data, out_ready,
        output cmd_ready, debug_en, debug_step, debug_addr,
               out_valid, out_addr, out_data, out_last, busy
    );

    modport slave (
        output cmd_valid, cmd_run, cmd_steps, debug_data, out_ready,
        input  cmd_ready, debug_en, debug_step, debug_addr,
               out_valid, out_addr, out_data, out_last, busy
    );
endinterface

// File: rtl/debug_probe.sv
// -----------------------------------------------------------------------------
// debug_probe
// Host-side driver for the RV32 core debug port. A step-and-dump command
// freezes the core (debug_en), issues cmd_steps pulses on debug_step, then
// sweeps debug_addr over the register file and streams each captured
// debug_data word out on a valid/ready interface. A run command releases
// the core.
//
// Ports:
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : debug_probe_if.master (command handshake, core debug pins,
//          output stream, busy)
//
// Build option DEBUG_PROBE_TESTSIG_EN: when defined the sweep covers
// addresses 0-63 (registers plus test-signal window); otherwise 0-31 and
// debug_addr[5] stays 0.
//
// State table:
//   IDLE    | waiting for a command; cmd_ready high
//   ARM     | one cycle to let debug_en settle before any step edge
//   STEP_HI | debug_step high for STEP_HIGH cycles
//   STEP_LO | debug_step low for STEP_LOW cycles, then step count decrements
//   ADDR    | debug_addr held SETTLE cycles, data captured on the last one
//   SEND    | captured word presented until out_ready
// -----------------------------------------------------------------------------
module debug_probe #(
    parameter int STEP_W    = 8,
    parameter int STEP_HIGH = 4,
    parameter int STEP_LOW  = 4,
    parameter int SETTLE    = 2
) (
    input  logic          clk,
    input  logic          rst,
    debug_probe_if.master bus
);

`ifdef DEBUG_PROBE_TESTSIG_EN
    localparam int ADDR_W = 6;
`else
    localparam int ADDR_W = 5;
`endif
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    localparam int TMR_MAX0 = (STEP_HIGH > STEP_LOW) ? STEP_HIGH : STEP_LOW;
    localparam int TMR_MAX  = (TMR_MAX0 > SETTLE) ? TMR_MAX0 : SETTLE;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_STEP_HI,
        S_STEP_LO,
        S_ADDR,
        S_SEND
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [TMR_W-1:0]  r_tmr;
    logic [TMR_W-1:0]  w_tmr_nxt;
    logic [STEP_W-1:0] r_step_cnt;
    logic [STEP_W-1:0] w_step_cnt_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_debug_en;
    logic              w_debug_en_nxt;
    logic              r_debug_step;
    logic              r_busy;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic [31:0]       r_out_data;
    logic [31:0]       w_out_data_nxt;
    logic [5:0]        r_out_addr;
    logic [5:0]        w_out_addr_nxt;
    logic              r_out_last;
    logic              w_out_last_nxt;

    logic              w_cmd_ready;
    logic              w_cmd_accept;
    logic              w_tmr_done;

    assign w_cmd_ready  = !rst && (r_state == S_IDLE);
    assign w_cmd_accept = bus.cmd_valid && w_cmd_ready;
    assign w_tmr_done   = (r_tmr == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_accept && !bus.cmd_run) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                w_state_nxt = (r_step_cnt == '0) ? S_ADDR : S_STEP_HI;
            end
            S_STEP_HI: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_STEP_LO;
                end
            end
            S_STEP_LO: begin
                // Counter is decremented on this same edge, so 1 means last pulse.
                if (w_tmr_done) begin
                    w_state_nxt = (r_step_cnt == STEP_W'(1)) ? S_ADDR : S_STEP_HI;
                end
            end
            S_ADDR: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    w_state_nxt = r_out_last ? S_IDLE : S_ADDR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_tmr_nxt       = r_tmr;
        w_step_cnt_nxt  = r_step_cnt;
        w_addr_nxt      = r_addr;
        w_debug_en_nxt  = r_debug_en;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_addr_nxt  = r_out_addr;
        w_out_last_nxt  = r_out_last;

        // The phase timer reloads on every state entry, so each timed state
        // lasts exactly its programmed length and ends on terminal count 0.
        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_STEP_HI: w_tmr_nxt = TMR_W'(STEP_HIGH - 1);
                S_STEP_LO: w_tmr_nxt = TMR_W'(STEP_LOW - 1);
                S_ADDR:    w_tmr_nxt = TMR_W'(SETTLE - 1);
                default:   w_tmr_nxt = '0;
            endcase
        end else if (!w_tmr_done) begin
            w_tmr_nxt = r_tmr - TMR_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_cmd_accept) begin
                    w_debug_en_nxt = !bus.cmd_run;
                    if (!bus.cmd_run) begin
                        w_step_cnt_nxt = bus.cmd_steps;
                        w_addr_nxt     = '0;
                    end
                end
            end
            S_STEP_LO: begin
                if (w_tmr_done) begin
                    w_step_cnt_nxt = r_step_cnt - STEP_W'(1);
                end
            end
            S_ADDR: begin
                if (w_tmr_done) begin
                    w_out_data_nxt  = bus.debug_data;
                    w_out_addr_nxt  = 6'(r_addr);
                    w_out_last_nxt  = (r_addr == ADDR_LAST);
                    w_out_valid_nxt = 1'b1;
                end
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_addr_nxt      = r_out_last ? '0 : (r_addr + ADDR_W'(1));
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr        <= '0;
            r_step_cnt   <= '0;
            r_addr       <= '0;
            r_debug_en   <= 1'b0;
            r_debug_step <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_addr   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_tmr        <= w_tmr_nxt;
            r_step_cnt   <= w_step_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_debug_en   <= w_debug_en_nxt;
            r_debug_step <= (w_state_nxt == S_STEP_HI);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_addr   <= w_out_addr_nxt;
            r_out_last   <= w_out_last_nxt;
        end
    end

    assign bus.cmd_ready  = w_cmd_ready;
    assign bus.debug_en   = r_debug_en;
    assign bus.debug_step = r_debug_step;
    assign bus.debug_addr = 7'(r_addr);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_addr   = r_out_addr;
    assign bus.out_last   = r_out_last;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_debug_probe.sv
module tb_debug_probe;

    localparam int SW    = 8;
    localparam int H     = 4;
    localparam int L     = 4;
    localparam int S     = 2;
    localparam int BOUND = 6000;
`ifdef DEBUG_PROBE_TESTSIG_EN
    localparam int LAST = 63;
`else
    localparam int LAST = 31;
`endif

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    logic [31:0] mem [0:127];

    debug_probe_if #(.STEP_W(SW)) bus_if ();

    debug_probe #(
        .STEP_W   (SW),
        .STEP_HIGH(H),
        .STEP_LOW (L),
        .SETTLE   (S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // Core model: debug_data is a combinational lookup of debug_addr.
    assign bus_if.debug_data = mem[bus_if.debug_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    32'(bus_if.debug_en),   0);
        chk({tag, "_step"},  32'(bus_if.debug_step), 0);
        chk({tag, "_addr"},  32'(bus_if.debug_addr), 0);
        chk({tag, "_valid"}, 32'(bus_if.out_valid),  0);
        chk({tag, "_odata"}, bus_if.out_data,        0);
        chk({tag, "_oaddr"}, 32'(bus_if.out_addr),   0);
        chk({tag, "_last"},  32'(bus_if.out_last),   0);
        chk({tag, "_busy"},  32'(bus_if.busy),       0);
    endtask

    // Reference behaviour derived from the command timeline:
    //   cycle 1 after the accept edge is ARM, pulses start at cycle 2, each
    //   pulse takes H+L cycles, the dump starts at D = 2 + n*(H+L) and each
    //   word takes S+1 cycles with out_ready held high.
    // mode 0: out_ready always 1; mode 1: 10-cycle stall on word 5;
    // mode 2: random out_ready. hold_cmd pushes a run command while busy.
    task automatic run_cmd(input int n, input int mode, input bit hold_cmd, input int abort_at);
        int  k, d, w, bp, rises;
        bit  done, rdy, prev_step, bp_used, exp_step, exp_valid;
        d = 2 + n * (H + L);
        w = 0; bp = 0; rises = 0;
        done = 0; prev_step = 0; bp_used = 0;

        bus_if.cmd_run   = 1'b0;
        bus_if.cmd_steps = SW'(n);
        bus_if.cmd_valid = 1'b1;
        bus_if.out_ready = 1'b0;
        chk("accept_ready", 32'(bus_if.cmd_ready), 1);
        cyc();
        bus_if.cmd_valid = hold_cmd;
        bus_if.cmd_run   = hold_cmd;
        k = 1;
        while (!done && k < BOUND) begin
            exp_step = (k >= 2) && (k < d) && (((k - 2) % (H + L)) < H);
            chk("step", 32'(bus_if.debug_step), 32'(exp_step));
            chk("en_busy", 32'(bus_if.debug_en), 1);
            chk("busy", 32'(bus_if.busy), 1);
            chk("ready_busy", 32'(bus_if.cmd_ready), 0);
            if (bus_if.debug_step && !prev_step) rises++;
            prev_step = bus_if.debug_step;

            if (k == abort_at) begin
                rst = 1'b1;
                cyc();
                chk_all_zero("abort");
                chk("abort_ready", 32'(bus_if.cmd_ready), 0);
                rst = 1'b0;
                #1;
                chk("abort_ready_rel", 32'(bus_if.cmd_ready), 1);
                cyc();
                chk("abort_busy2", 32'(bus_if.busy), 0);
                return;
            end

            if (k < d) begin
                chk("addr_step", 32'(bus_if.debug_addr), 0);
                chk("valid_step", 32'(bus_if.out_valid), 0);
            end else begin
                chk("dbg_addr", 32'(bus_if.debug_addr), 32'(w));
                if (mode == 0) begin
                    exp_valid = (((k - d) % (S + 1)) == S);
                    chk("valid_time", 32'(bus_if.out_valid), 32'(exp_valid));
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: begin
                        if (w == 5 && bus_if.out_valid && !bp_used) begin
                            bp = 10;
                            bp_used = 1'b1;
                        end
                        rdy = (bp == 0);
                        if (bp > 0) bp--;
                    end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                bus_if.out_ready = rdy;
                if (bus_if.out_valid) begin
                    chk("out_addr", 32'(bus_if.out_addr), 32'(w));
                    chk("out_data", bus_if.out_data, mem[w]);
                    chk("out_last", 32'(bus_if.out_last), 32'(w == LAST));
                    if (rdy) begin
                        if (w == LAST) begin
                            done = 1'b1;
                            bus_if.cmd_valid = 1'b0;
                        end
                        w++;
                    end
                end
            end
            cyc();
            k++;
        end
        bus_if.out_ready = 1'b0;
        chk("dump_done", 32'(done), 1);
        chk("words", 32'(w), 32'(LAST + 1));
        chk("pulses", 32'(rises), 32'(n));
        chk("end_busy", 32'(bus_if.busy), 0);
        chk("end_valid", 32'(bus_if.out_valid), 0);
        chk("end_addr", 32'(bus_if.debug_addr), 0);
        chk("end_en", 32'(bus_if.debug_en), 1);
        chk("end_step", 32'(bus_if.debug_step), 0);
        chk("end_ready", 32'(bus_if.cmd_ready), 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
        rst              = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_run   = 1'b0;
        bus_if.cmd_steps = '0;
        bus_if.out_ready = 1'b0;

        // Reset: two cycles, outputs zero, cmd_ready low while in reset.
        cyc();
        chk_all_zero("rst1");
        chk("rst1_ready", 32'(bus_if.cmd_ready), 0);
        cyc();
        chk_all_zero("rst2");
        chk("rst2_ready", 32'(bus_if.cmd_ready), 0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(bus_if.cmd_ready), 1);
        cyc();
        chk("rel_ready2", 32'(bus_if.cmd_ready), 1);
        chk_all_zero("rel");

        // Dump only with identity data.
        run_cmd(0, 0, 1'b0, 0);

        // Three step pulses, random data.
        fill_random();
        run_cmd(3, 0, 1'b0, 0);

        // Back-pressure at word 5.
        fill_random();
        run_cmd($urandom_range(1, 4), 1, 1'b0, 0);

        // Random out_ready, run command pushed while busy must be ignored.
        fill_random();
        run_cmd($urandom_range(0, 3), 2, 1'b1, 0);

        // Release the core.
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_run   = 1'b1;
        chk("run_ready", 32'(bus_if.cmd_ready), 1);
        cyc();
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_run   = 1'b0;
        chk("run_en", 32'(bus_if.debug_en), 0);
        chk("run_busy", 32'(bus_if.busy), 0);
        chk("run_step", 32'(bus_if.debug_step), 0);
        cyc();
        chk("run_busy2", 32'(bus_if.busy), 0);
        chk("run_ready2", 32'(bus_if.cmd_ready), 1);

        // Abort in the middle of the second step-high phase.
        run_cmd(3, 0, 1'b0, 2 + (H + L) + 1);

        // A fresh command after the abort runs normally.
        fill_random();
        run_cmd(2, 0, 1'b0, 0);

        // Maximum step count: no wrap of the step counter.
        fill_random();
        run_cmd((1 << SW) - 1, 0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
